seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//   Multi-cycle radix-2 restoring divider: the DIV execution unit that feeds the Z register pair.
//   The control step that issues opcode 01111 pulses start with Y (dividend) and bus (divisor).
//   It holds the step until done; Zhigh (remainder) -> HI, Zlow (quotient) -> LO.
//   Replaces a single-cycle combinational divide; one quotient bit per clock.
// PARAMETERS
//   WIDTH   32   operand/quotient/remainder width in bits (>= 4)
// PORTS
//   clock      in   1        system clock, all state on rising edge
//   clear      in   1        asynchronous, active-low reset
//   start      in   1        request; sampled only in IDLE
//   signed_op  in   1        1 = two's-complement divide, 0 = unsigned; captured with start
//   dividend   in   WIDTH    numerator (Y); captured with start
//   divisor    in   WIDTH    denominator (bus); captured with start
//   busy       out  1        high from the cycle after start is accepted until done
//   done       out  1        one-cycle pulse, results valid
//   div_zero   out  1        divisor was 0 for the last operation; held with results
//   z_result   out  2*WIDTH  {remainder, quotient}; high half -> Zhigh, low half -> Zlow
// BEHAVIOUR
//   Reset (clear=0, any state, any time): state=IDLE; busy=0, done=0, div_zero=0, z_result=0.
//     An in-flight divide is discarded with no done pulse.
//   FSM: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> DONE -> IDLE.
//   IDLE: start=1 on edge k latches operands and signed_op -> PREP. start in any other state is ignored.
//   PREP (edge k+1): takes magnitudes |dividend| and |divisor| when signed_op=1.
//     Records q_neg = sign(dd)^sign(dv) and r_neg = sign(dd). Clears rem and count -> ITER.
//   ITER: each edge: rem = {rem,msb(q)}; q<<=1; if rem >= dv then rem -= dv and q[0]=1.
//     rem register is WIDTH+1 bits; no truncation.
//     Leaves after count hits WIDTH-1 (edges k+2 .. k+WIDTH+1).
//   FIX (edge k+WIDTH+2): negates quotient if q_neg and remainder if r_neg.
//     Registers z_result and div_zero -> DONE.
//   DONE: done=1 for exactly this one cycle; busy=0. Next edge -> IDLE. start in DONE is ignored.
//   Latency: done high in the cycle after edge k+WIDTH+2; WIDTH=32 gives 34 edges after the sampling edge.
//   Truncating division: quotient rounds toward zero; remainder takes the dividend's sign;
//     dividend = q*divisor + r.
//   Overflow: signed MIN / -1 -> quotient = MIN (wraps), remainder = 0, div_zero=0; no trap.
//   Divisor = 0: div_zero=1, quotient = all ones, remainder = original dividend
//     (sign-unmodified), regardless of signed_op.
//   z_result and div_zero hold their last values until the next FIX or reset.
//     They are not cleared on start.
//   busy = (state != IDLE && state != DONE).
// CONFIGURATION
//   DIV_EARLY_ZERO_EN defined: PREP detects divisor==0 and goes directly to FIX, skipping ITER.
//     Divide-by-zero latency is 2 edges after sampling; results are as specified above.
//   Not defined: a zero divisor runs the full ITER sequence with normal latency.
//     FIX forces the divide-by-zero results. Non-zero divisor timing is identical in both builds.
// TESTING
//   1 signed, 0x00000FF5 / 0xFFFFFFFD -> quotient 0xFFFFFAAF, remainder 0x00000002,
//     z_result=0x00000002_FFFFFAAF; done exactly 34 edges after start edge.
//   2 unsigned, 0xFFFFFFFD / 0x00000010 -> quotient 0x0FFFFFFF, remainder 0x0000000D;
//     signed, -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF.
//   3 signed, 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_zero=0.
//   4 divisor 0, dividend 0x12345678 -> q=0xFFFFFFFF, r=0x12345678, div_zero=1.
//     Done at edge k+34 without DIV_EARLY_ZERO_EN, at edge k+2 with it.
//   5 start held high for 40 cycles -> ops back-to-back with one DONE gap.
//     Second op's operands are sampled on the edge after DONE; busy never asserted in DONE.
//   6 clear pulsed low at ITER cycle 10 -> outputs all 0 immediately (async), no done pulse;
//     next start completes normally with the same latency.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock.
// Define DIV_EARLY_ZERO_EN to skip the iteration phase when the divisor is zero.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] z_result
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     dd_q, dd_d;
  logic [WIDTH-1:0]     dv_q, dv_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 signed_q, signed_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0]   z_q, z_d;
  logic                 dz_q, dz_d;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_lo;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= StIdle;
      dd_q     <= '0;
      dv_q     <= '0;
      q_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      z_q      <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dd_q     <= dd_d;
      dv_q     <= dv_d;
      q_q      <= q_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      z_q      <= z_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dd_d     = dd_q;
    dv_d     = dv_q;
    q_d      = q_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    z_d      = z_q;
    dz_d     = dz_q;
    rem_sh   = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
    rem_lo   = rem_q[WIDTH-1:0];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dd_d     = dividend;
          dv_d     = divisor;
          signed_d = signed_op;
          state_d  = StPrep;
        end
      end
      StPrep: begin
        // dd_q keeps the original dividend for the divide-by-zero remainder
        q_d     = (signed_q && dd_q[WIDTH-1]) ? -dd_q : dd_q;
        dv_d    = (signed_q && dv_q[WIDTH-1]) ? -dv_q : dv_q;
        q_neg_d = signed_q & (dd_q[WIDTH-1] ^ dv_q[WIDTH-1]);
        r_neg_d = signed_q & dd_q[WIDTH-1];
        rem_d   = '0;
        cnt_d   = '0;
        state_d = StIter;
`ifdef DIV_EARLY_ZERO_EN
        if (dv_q == '0) state_d = StFix;
`else
`endif
      end
      StIter: begin
        if (rem_sh >= {1'b0, dv_q}) begin
          rem_d = rem_sh - {1'b0, dv_q};
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFix: begin
        if (dv_q == '0) begin
          z_d  = {dd_q, {WIDTH{1'b1}}};
          dz_d = 1'b1;
        end else begin
          z_d  = {(r_neg_q ? -rem_lo : rem_lo), (q_neg_q ? -q_q : q_q)};
          dz_d = 1'b0;
        end
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign done     = (state_q == StDone);
  assign div_zero = dz_q;
  assign z_result = z_q;

endmodule
